// File: rtl/store_bus_writer_if.sv
// Bridge write bus between the M-stage store writer (master) and the bridge (slave).
interface store_bus_writer_if;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_byteen;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic        bus_err;

  modport master (
    output bus_we, bus_addr, bus_byteen, bus_wdata, bus_err,
    input  bus_ack
  );

  modport slave (
    input  bus_we, bus_addr, bus_byteen, bus_wdata, bus_err,
    output bus_ack
  );
endinterface

// File: rtl/store_bus_writer.sv
// M-stage store unit: AdES checking, byte-lane placement and a held bridge write with ack timeout.
// Optional macro STORE_BADVADDR_EN adds the bad_vaddr capture register for CP0 BadVAddr.
module store_bus_writer #(
  parameter int ACK_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [1:0]  st_op,
  input  logic [31:0] A,
  input  logic [31:0] Din,
  input  logic        alu_ov,
  input  logic        flush,
  output logic        req_ready,
  output logic        exc_ades,
  store_bus_writer_if.master bus
`ifdef STORE_BADVADDR_EN
  ,
  output logic [31:0] bad_vaddr
`endif
);

  localparam logic [1:0]      OP_SW   = 2'b00;
  localparam logic [1:0]      OP_SH   = 2'b01;
  localparam logic [1:0]      OP_RSV  = 2'b11;
  localparam logic [TO_W-1:0] LP_LAST = TO_W'(ACK_TIMEOUT - 1);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t          r_state, w_next;
  logic [TO_W-1:0] r_cnt;
  logic            r_we, r_err;
  logic [31:0]     r_addr, r_wdata;
  logic [3:0]      r_byteen;
  logic            w_req, w_bad, w_accept, w_last;

  function automatic logic f_ades(input logic [1:0] op, input logic [31:0] a, input logic ov);
    logic in_map, in_tmr, ro;
    in_map = (a <= 32'h0000_2fff) ||
             (a >= 32'h0000_7f00 && a <= 32'h0000_7f0b) ||
             (a >= 32'h0000_7f10 && a <= 32'h0000_7f1b) ||
             (a >= 32'h0000_7f20 && a <= 32'h0000_7f23);
    in_tmr = (a >= 32'h0000_7f00 && a <= 32'h0000_7f1b);
    ro     = (a >= 32'h0000_7f08 && a <= 32'h0000_7f0b) ||
             (a >= 32'h0000_7f18 && a <= 32'h0000_7f1b);
    return ov || !in_map || ro || (op == OP_SW && a[1:0] != 2'b00) ||
           (op == OP_SH && a[0]) || (op != OP_SW && in_tmr);
  endfunction

  function automatic logic [3:0] f_byteen(input logic [1:0] op, input logic [1:0] lo);
    case (op)
      OP_SW:   return 4'b1111;
      OP_SH:   return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b0001 << lo;
    endcase
  endfunction

  function automatic logic [31:0] f_wdata(input logic [1:0] op, input logic [31:0] d);
    case (op)
      OP_SW:   return d;
      OP_SH:   return {d[15:0], d[15:0]};
      default: return {4{d[7:0]}};
    endcase
  endfunction

  assign w_req    = req_valid && (st_op != OP_RSV) && !flush;
  assign w_bad    = f_ades(st_op, A, alu_ov);
  assign w_accept = w_req && req_ready && !w_bad;
  assign w_last   = (r_cnt == LP_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_WAIT;
      ST_WAIT: if (bus.bus_ack || w_last) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == ST_IDLE);
    exc_ades  = w_req && req_ready && w_bad;
  end

  // Ack takes priority over the timeout when both land on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= '0;
      r_byteen <= '0;
      r_wdata  <= '0;
    end else begin
      r_err <= 1'b0;
      if (w_accept) begin
        r_we     <= 1'b1;
        r_cnt    <= '0;
        r_addr   <= {A[31:2], 2'b00};
        r_byteen <= f_byteen(st_op, A[1:0]);
        r_wdata  <= f_wdata(st_op, Din);
      end else if (r_state == ST_WAIT) begin
        if (bus.bus_ack) begin
          r_we     <= 1'b0;
          r_byteen <= '0;
        end else if (w_last) begin
          r_we  <= 1'b0;
          r_err <= 1'b1;
        end else begin
          r_cnt <= r_cnt + TO_W'(1);
        end
      end
    end
  end

  assign bus.bus_we     = r_we;
  assign bus.bus_addr   = r_addr;
  assign bus.bus_byteen = r_byteen;
  assign bus.bus_wdata  = r_wdata;
  assign bus.bus_err    = r_err;

`ifdef STORE_BADVADDR_EN
  logic [31:0] r_bad_vaddr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_bad_vaddr <= '0;
    else if (exc_ades) r_bad_vaddr <= A;
  end

  assign bad_vaddr = r_bad_vaddr;
`endif

endmodule

// File: tb/tb_store_bus_writer.sv
// Directed bench for store_bus_writer with a cycle-level reference model and literal spot checks.
module tb_store_bus_writer;
  localparam int ACK_TIMEOUT = 16;
  localparam int TO_W        = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [1:0]  st_op = 2'b00;
  logic [31:0] A = '0;
  logic [31:0] Din = '0;
  logic        alu_ov = 1'b0;
  logic        flush = 1'b0;
  logic        req_ready, exc_ades;
`ifdef STORE_BADVADDR_EN
  logic [31:0] bad_vaddr;
`endif

  store_bus_writer_if bus();

  store_bus_writer #(.ACK_TIMEOUT(ACK_TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .st_op(st_op), .A(A), .Din(Din),
    .alu_ov(alu_ov), .flush(flush), .req_ready(req_ready), .exc_ades(exc_ades), .bus(bus)
`ifdef STORE_BADVADDR_EN
    , .bad_vaddr(bad_vaddr)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules written from the address map, independent of any state encoding.
  function automatic bit m_bad(input logic [1:0] op, input logic [31:0] a, input logic ov);
    bit dm, t0, t1, ig;
    if (ov) return 1'b1;
    if (op == 2'd0 && (a % 4) != 0) return 1'b1;
    if (op == 2'd1 && (a % 2) != 0) return 1'b1;
    dm = (a <= 32'h2fff);
    t0 = (a >= 32'h7f00 && a <= 32'h7f0b);
    t1 = (a >= 32'h7f10 && a <= 32'h7f1b);
    ig = (a >= 32'h7f20 && a <= 32'h7f23);
    if (!(dm || t0 || t1 || ig)) return 1'b1;
    if (op != 2'd0 && (t0 || t1)) return 1'b1;
    if ((a >= 32'h7f08 && a <= 32'h7f0b) || (a >= 32'h7f18 && a <= 32'h7f1b)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_en(input logic [1:0] op, input logic [31:0] a);
    if (op == 2'd0) return 4'hf;
    if (op == 2'd1) return ((a % 4) >= 2) ? 4'hc : 4'h3;
    return 4'(1 << (a % 4));
  endfunction

  function automatic logic [31:0] m_data(input logic [1:0] op, input logic [31:0] d);
    logic [31:0] r;
    if (op == 2'd0) r = d;
    else if (op == 2'd1) r = (d & 32'hffff) * 32'h0001_0001;
    else r = (d & 32'hff) * 32'h0101_0101;
    return r;
  endfunction

  bit          m_busy = 1'b0, m_we = 1'b0, m_err = 1'b0;
  int          m_waits = 0;
  logic [31:0] m_addr = '0, m_wd = '0, m_bva = '0;
  logic [3:0]  m_be = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_we <= 1'b0; m_err <= 1'b0; m_waits <= 0;
      m_addr <= '0; m_wd <= '0; m_be <= '0; m_bva <= '0;
    end else begin
      m_err <= 1'b0;
      if (m_busy) begin
        if (bus.bus_ack) begin
          m_busy <= 1'b0; m_we <= 1'b0; m_be <= '0;
        end else if (m_waits + 1 == ACK_TIMEOUT) begin
          m_busy <= 1'b0; m_we <= 1'b0; m_err <= 1'b1;
        end else begin
          m_waits <= m_waits + 1;
        end
      end else if (req_valid && st_op != 2'd3 && !flush) begin
        if (m_bad(st_op, A, alu_ov)) m_bva <= A;
        else begin
          m_busy <= 1'b1; m_we <= 1'b1; m_waits <= 0;
          m_addr <= A - (A % 4); m_be <= m_en(st_op, A); m_wd <= m_data(st_op, Din);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", 32'(req_ready), 32'(!m_busy));
      check("exc_ades", 32'(exc_ades),
            32'(!m_busy && req_valid && st_op != 2'd3 && !flush && m_bad(st_op, A, alu_ov)));
      check("bus_we", 32'(bus.bus_we), 32'(m_we));
      check("bus_addr", bus.bus_addr, m_addr);
      check("bus_byteen", 32'(bus.bus_byteen), 32'(m_be));
      check("bus_wdata", bus.bus_wdata, m_wd);
      check("bus_err", 32'(bus.bus_err), 32'(m_err));
`ifdef STORE_BADVADDR_EN
      check("bad_vaddr", bad_vaddr, m_bva);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                         input logic ov);
    req_valid = 1'b1; st_op = op; A = a; Din = d; alu_ov = ov;
  endtask

  task automatic clr_req();
    req_valid = 1'b0; st_op = 2'b00; A = '0; Din = '0; alu_ov = 1'b0;
  endtask

  task automatic store_ack(input string nm, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] ea, input logic [3:0] ebe,
                           input logic [31:0] ewd);
    set_req(op, a, d, 1'b0);
    @(negedge clk);
    check({nm, "_ades0"}, 32'(exc_ades), 32'd0);
    tick();
    clr_req();
    bus.bus_ack = 1'b1;
    @(negedge clk);
    check({nm, "_we"}, 32'(bus.bus_we), 32'd1);
    check({nm, "_addr"}, bus.bus_addr, ea);
    check({nm, "_be"}, 32'(bus.bus_byteen), 32'(ebe));
    check({nm, "_wd"}, bus.bus_wdata, ewd);
    check({nm, "_busy"}, 32'(req_ready), 32'd0);
    tick();
    bus.bus_ack = 1'b0;
    @(negedge clk);
    check({nm, "_done_we"}, 32'(bus.bus_we), 32'd0);
    check({nm, "_ready"}, 32'(req_ready), 32'd1);
  endtask

  logic [1:0]  ades_op [5] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
  logic [31:0] ades_a  [5] = '{32'h6, 32'h7f04, 32'h7f08, 32'h3000, 32'h0};
  logic        ades_ov [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.bus_ack = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_we", 32'(bus.bus_we), 32'd0);
    check("rst_addr", bus.bus_addr, 32'd0);
    check("rst_err", 32'(bus.bus_err), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    tick();
    reset = 1'b0;
    tick();

    store_ack("sw", 2'd0, 32'h1004, 32'hdeadbeef, 32'h1004, 4'b1111, 32'hdeadbeef);
    tick();
    store_ack("sb", 2'd2, 32'h2003, 32'h000000a5, 32'h2000, 4'b1000, 32'ha5a5a5a5);
    tick();
    store_ack("sh", 2'd1, 32'h0002, 32'h00001234, 32'h0000, 4'b1100, 32'h12341234);
    tick();

    for (int i = 0; i < 5; i++) begin
      set_req(ades_op[i], ades_a[i], 32'h11111111, ades_ov[i]);
      @(negedge clk);
      check($sformatf("ades%0d", i), 32'(exc_ades), 32'd1);
      tick();
      clr_req();
      @(negedge clk);
      check($sformatf("ades%0d_nowe", i), 32'(bus.bus_we), 32'd0);
      tick();
    end

    bus.bus_ack = 1'b1;
    tick();
    bus.bus_ack = 1'b0;
    @(negedge clk);
    check("idle_ack_ready", 32'(req_ready), 32'd1);
    tick();

    set_req(2'd0, 32'h7f20, 32'hcafef00d, 1'b0);
    tick();
    clr_req();
    repeat (15) tick();
    @(negedge clk);
    check("to_still_we", 32'(bus.bus_we), 32'd1);
    check("to_no_err_yet", 32'(bus.bus_err), 32'd0);
    tick();
    @(negedge clk);
    check("to_err", 32'(bus.bus_err), 32'd1);
    check("to_we_off", 32'(bus.bus_we), 32'd0);
    check("to_ready", 32'(req_ready), 32'd1);
    tick();
    @(negedge clk);
    check("to_err_pulse", 32'(bus.bus_err), 32'd0);
    tick();

    set_req(2'd0, 32'h7f20, 32'h0badf00d, 1'b0);
    tick();
    clr_req();
    repeat (15) tick();
    bus.bus_ack = 1'b1;
    tick();
    bus.bus_ack = 1'b0;
    @(negedge clk);
    check("ackwin_err", 32'(bus.bus_err), 32'd0);
    check("ackwin_we", 32'(bus.bus_we), 32'd0);
    check("ackwin_be", 32'(bus.bus_byteen), 32'd0);
    tick();

    set_req(2'd0, 32'h0010, 32'h01020304, 1'b0);
    tick();
    set_req(2'd0, 32'h0020, 32'h55555555, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    check("fl_busy", 32'(req_ready), 32'd0);
    tick();
    flush = 1'b0;
    set_req(2'd0, 32'h0006, 32'h66666666, 1'b0);
    @(negedge clk);
    check("wait_no_ades", 32'(exc_ades), 32'd0);
    tick();
    set_req(2'd0, 32'h0024, 32'h77777777, 1'b0);
    bus.bus_ack = 1'b1;
    @(negedge clk);
    check("fl_still_we", 32'(bus.bus_we), 32'd1);
    check("fl_addr", bus.bus_addr, 32'h0010);
    tick();
    bus.bus_ack = 1'b0;
    @(negedge clk);
    check("held_ready", 32'(req_ready), 32'd1);
    check("held_we", 32'(bus.bus_we), 32'd0);
    tick();
    clr_req();
    @(negedge clk);
    check("held_acc_addr", bus.bus_addr, 32'h0024);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("rstw_we", 32'(bus.bus_we), 32'd0);
    check("rstw_err", 32'(bus.bus_err), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rstw_err2", 32'(bus.bus_err), 32'd0);
    tick();

`ifdef STORE_BADVADDR_EN
    set_req(2'd1, 32'h0011, 32'h0, 1'b0);
    @(negedge clk);
    check("bva_ades", 32'(exc_ades), 32'd1);
    tick();
    clr_req();
    @(negedge clk);
    check("bva_load", bad_vaddr, 32'h00000011);
    tick();
    store_ack("bva_sw", 2'd0, 32'h0040, 32'h89abcdef, 32'h0040, 4'b1111, 32'h89abcdef);
    check("bva_hold", bad_vaddr, 32'h00000011);
    tick();
`endif

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
